frog_game_ctrl: RTL and testbench
=================================

# frog_game_ctrl

Per-frame game-state controller that sits downstream of the car rows. It consumes each row's `Car_Collision` and the frog position, and tracks lives, level and score. It drives the `win`/`lose` signals and the level-scaled `Speed` back into every car row. One instance serves the whole road; it advances once per `frame_clk` edge.

## Interface
Parameters:
- NUM_ROWS, 5: number of car rows feeding `Car_Collision`.
- LIVES, 3: lives granted at game start (1..3).
- GOAL_Y, 11'd40: frog reaches goal when `Frog_Y <= GOAL_Y`.
- DEATH_FRAMES, 6'd30: frames held in DEAD (1..63).
- BASE_SPEED, 6'd4: speed at level 0.
- SPEED_STEP, 6'd3: speed added per level.
- MAX_LEVEL, 3'd7: level saturation value.

Ports:
- frame_clk  in  1  frame-rate clock; all state advances on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  start/restart request, level-sensitive, sampled each edge.
- Car_Collision  in  NUM_ROWS  per-row collision flags.
- Row_Enable  in  NUM_ROWS  1 = row active this level; disabled rows are ignored.
- Frog_Y  in  11  frog top y coordinate in pixels.
- win  out  1  one-frame level-complete pulse to car rows.
- lose  out  1  high for the whole DEAD interval (car rows freeze/reset).
- Game_Over  out  1  high in GAME_OVER.
- Game_State  out  3  state encoding: IDLE=0, PLAY=1, DEAD=2, LEVEL_UP=3, GAME_OVER=4.
- Lives  out  2  remaining lives.
- Level  out  3  current level.
- Speed  out  6  speed for all car rows.
- Score  out  16  levels completed since start, saturating at 16'hFFFF.

## Operation
- Reset: state IDLE, `Lives=LIVES`, `Level=0`, `Score=0`, death counter 0, `win=0`, `lose=0`, `Game_Over=0`, `Speed=BASE_SPEED`.
- `hit = |(Car_Collision & Row_Enable)`.
- `goal = Frog_Y <= GOAL_Y`, unsigned compare.
- IDLE:
  - If Start: go to PLAY, load `Lives=LIVES`, `Level=0`, `Score=0`.
  - Otherwise stay.
- PLAY:
  - If hit: go to DEAD, `Lives` decrements by 1 on the same edge, death counter cleared.
  - Else if goal: go to LEVEL_UP.
  - Otherwise stay.
  - Hit has priority over goal when both occur in the same frame.
- DEAD:
  - Death counter increments each edge.
  - When the counter equals DEATH_FRAMES-1: go to GAME_OVER if `Lives==0`, else go to PLAY.
  - Inputs (hit, goal, Start) are ignored in DEAD.
- LEVEL_UP:
  - On the next edge, go to PLAY.
  - `Level` increments, saturating at MAX_LEVEL.
  - `Score` increments, saturating at 16'hFFFF.
- GAME_OVER:
  - If Start: go to PLAY with `Lives=LIVES`, `Level=0`, `Score=0`.
  - Otherwise hold. `Lives` stays 0.
- `Lives` never underflows: a decrement occurs only on the PLAY→DEAD transition, and PLAY is unreachable with `Lives==0`.
- `Speed = min(BASE_SPEED + Level*SPEED_STEP, 63)`.
  - Computed at 10-bit width, then clipped to 6 bits.
  - Registered, so it updates one edge after `Level` changes.
- Outputs decoded from registered state:
  - `win = (state==LEVEL_UP)`.
  - `lose = (state==DEAD)`.
  - `Game_Over = (state==GAME_OVER)`.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Hit sampled at edge N → `lose=1` and `Lives` decremented after edge N.
  - `lose` stays high for exactly DEATH_FRAMES frames.
  - The state after DEAD is visible after edge N+DEATH_FRAMES.
- Goal sampled at edge N:
  - `win=1` for exactly one frame after edge N.
  - `Level` updates after edge N+1.
  - `Speed` updates after edge N+2.
- A hit held high across multiple frames costs exactly one life. The hit is only evaluated in PLAY.
- After DEAD returns to PLAY, a hit still asserted on the first PLAY edge costs another life. Car rows must have reset positions under `lose`.
- Reset asserted mid-operation (e.g. mid-DEAD): all state returns to reset values immediately and asynchronously. The first edge after deassertion evaluates IDLE.

## Test plan
- Reset, then Start=1 for one frame → PLAY next frame; `Lives=3`, `Level=0`, `Speed=4`, `win=0`, `lose=0`.
- In PLAY, `Car_Collision=5'b00100`, `Row_Enable=5'b11111` for one frame → `Lives=2`, `lose=1` for exactly 30 frames, then PLAY.
- `Car_Collision=5'b00100` with `Row_Enable=5'b11011` → stays PLAY, `Lives` unchanged.
- `Frog_Y=40` and `Car_Collision=5'b00001` in the same frame → DEAD (not LEVEL_UP), `win` stays 0.
- `Frog_Y=40` for 8 separate completions → `win` pulses 1 frame each; `Level` saturates at 7; `Speed` reaches min(4+21,63)=25; `Score=8`.
- Three hits → GAME_OVER after the third DEAD, `Game_Over=1`, `Lives=0`. Then Start=1 → PLAY with `Lives=3`, `Score=0`.
- Additional check: async Reset pulse in mid-DEAD between edges → IDLE immediately, `lose=0`.

Source files
------------

// File: rtl/frog_game_ctrl.sv
// Frame-rate game-state controller: tracks lives, level and score from row
// collisions and frog position, and drives win/lose/Speed back to the car rows.
module frog_game_ctrl #(
  parameter int unsigned NUM_ROWS     = 5,
  parameter int unsigned LIVES        = 3,
  parameter logic [10:0] GOAL_Y       = 11'd40,
  parameter logic [5:0]  DEATH_FRAMES = 6'd30,
  parameter logic [5:0]  BASE_SPEED   = 6'd4,
  parameter logic [5:0]  SPEED_STEP   = 6'd3,
  parameter logic [2:0]  MAX_LEVEL    = 3'd7
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [NUM_ROWS-1:0] Car_Collision,
  input  logic [NUM_ROWS-1:0] Row_Enable,
  input  logic [10:0]         Frog_Y,
  output logic                win,
  output logic                lose,
  output logic                Game_Over,
  output logic [2:0]          Game_State,
  output logic [1:0]          Lives,
  output logic [2:0]          Level,
  output logic [5:0]          Speed,
  output logic [15:0]         Score
);

  localparam int unsigned SUM_W = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DEAD      = 3'd2,
    LEVEL_UP  = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t             state;
  logic [5:0]         death_cnt;
  logic               hit;
  logic               goal;
  logic [SUM_W-1:0]   speed_sum;
  logic [5:0]         speed_clip;

  // Only enabled rows can kill the frog; goal is an unsigned compare on the top edge.
  always_comb begin
    hit        = |(Car_Collision & Row_Enable);
    goal       = (Frog_Y <= GOAL_Y);
    speed_sum  = SUM_W'(BASE_SPEED) + SUM_W'(Level) * SUM_W'(SPEED_STEP);
    speed_clip = (speed_sum > SUM_W'(63)) ? 6'd63 : speed_sum[5:0];
  end

  assign Game_State = state;

  // Game FSM; win/lose/Game_Over are registered alongside the state they decode.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      Lives     <= 2'(LIVES);
      Level     <= 3'd0;
      Score     <= 16'd0;
      death_cnt <= 6'd0;
      win       <= 1'b0;
      lose      <= 1'b0;
      Game_Over <= 1'b0;
      Speed     <= BASE_SPEED;
    end else begin
      Speed <= speed_clip;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= PLAY;
            Lives <= 2'(LIVES);
            Level <= 3'd0;
            Score <= 16'd0;
          end
        end
        PLAY: begin
          if (hit) begin
            state     <= DEAD;
            Lives     <= Lives - 2'd1;
            death_cnt <= 6'd0;
            lose      <= 1'b1;
          end else if (goal) begin
            state <= LEVEL_UP;
            win   <= 1'b1;
          end
        end
        DEAD: begin
          death_cnt <= death_cnt + 6'd1;
          if (death_cnt == DEATH_FRAMES - 6'd1) begin
            lose <= 1'b0;
            if (Lives == 2'd0) begin
              state     <= GAME_OVER;
              Game_Over <= 1'b1;
            end else begin
              state <= PLAY;
            end
          end
        end
        LEVEL_UP: begin
          state <= PLAY;
          win   <= 1'b0;
          if (Level != MAX_LEVEL) Level <= Level + 3'd1;
          if (Score != 16'hFFFF)  Score <= Score + 16'd1;
        end
        GAME_OVER: begin
          if (Start) begin
            state     <= PLAY;
            Game_Over <= 1'b0;
            Lives     <= 2'(LIVES);
            Level     <= 3'd0;
            Score     <= 16'd0;
          end
        end
        default: begin
          state     <= IDLE;
          win       <= 1'b0;
          lose      <= 1'b0;
          Game_Over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Scoreboard bench for frog_game_ctrl: directed frames push expected snapshots,
// a monitor pops and compares them after each frame edge or reset check.
module tb_frog_game_ctrl;

  localparam int unsigned NR = 5;
  localparam logic [2:0] S_IDLE = 3'd0, S_PLAY = 3'd1, S_DEAD = 3'd2,
                         S_LVUP = 3'd3, S_OVER = 3'd4;

  logic          frame_clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [NR-1:0] Car_Collision = '0;
  logic [NR-1:0] Row_Enable = 5'b11111;
  logic [10:0]   Frog_Y = 11'd200;
  logic          win, lose, Game_Over;
  logic [2:0]    Game_State, Level;
  logic [1:0]    Lives;
  logic [5:0]    Speed;
  logic [15:0]   Score;

  typedef struct packed {
    logic [2:0]  st;
    logic [1:0]  lives;
    logic [2:0]  level;
    logic [5:0]  speed;
    logic [15:0] score;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic chk_now = 1'b0;

  frog_game_ctrl dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .Start        (Start),
    .Car_Collision(Car_Collision),
    .Row_Enable   (Row_Enable),
    .Frog_Y       (Frog_Y),
    .win          (win),
    .lose         (lose),
    .Game_Over    (Game_Over),
    .Game_State   (Game_State),
    .Lives        (Lives),
    .Level        (Level),
    .Speed        (Speed),
    .Score        (Score)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    if (act !== expv) begin
      miscompares++;
      $display("FAIL vec %0d %s: got %0h expected %0h at %0t", vectors, name, act, expv, $time);
    end
  endtask

  // Monitor: compares the DUT against the oldest expectation after each edge.
  always begin
    @(posedge frame_clk or posedge chk_now);
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      chk("state",     16'(Game_State), 16'(e.st));
      chk("lives",     16'(Lives),      16'(e.lives));
      chk("level",     16'(Level),      16'(e.level));
      chk("speed",     16'(Speed),      16'(e.speed));
      chk("score",     Score,           e.score);
      chk("win",       16'(win),        16'(e.st == S_LVUP));
      chk("lose",      16'(lose),       16'(e.st == S_DEAD));
      chk("game_over", 16'(Game_Over),  16'(e.st == S_OVER));
    end
  end

  function automatic logic [5:0] spd(input int l);
    int s;
    s = 4 + 3 * l;
    return (s > 63) ? 6'd63 : 6'(s);
  endfunction

  // Expect the given snapshot after the coming edge, then move to the next negedge.
  task automatic frame(input logic [2:0] st, input int lv, input int lvl, input logic [5:0] sp, input int sc);
    exp_q.push_back('{st, 2'(lv), 3'(lvl), sp, 16'(sc)});
    @(negedge frame_clk);
  endtask

  // Assert reset between edges and check the outputs before the next edge.
  task automatic reset_check();
    Reset = 1'b1;
    #1;
    exp_q.push_back('{S_IDLE, 2'd3, 3'd0, 6'd4, 16'd0});
    chk_now = 1'b1;
    #2;
    chk_now = 1'b0;
    Reset = 1'b0;
  endtask

  initial begin
    int lvl;
    int sc;
    @(negedge frame_clk);
    @(negedge frame_clk);
    reset_check();
    @(negedge frame_clk);
    frame(S_IDLE, 3, 0, 4, 0);
    Start = 1'b1;
    frame(S_PLAY, 3, 0, 4, 0);
    Start = 1'b0;

    // Single-frame hit on an enabled row: 30 DEAD frames then PLAY.
    Car_Collision = 5'b00100;
    frame(S_DEAD, 2, 0, 4, 0);
    Car_Collision = '0;
    for (int i = 1; i < 30; i++) frame(S_DEAD, 2, 0, 4, 0);
    frame(S_PLAY, 2, 0, 4, 0);

    // Collision on a disabled row is ignored.
    Car_Collision = 5'b00100;
    Row_Enable = 5'b11011;
    frame(S_PLAY, 2, 0, 4, 0);
    frame(S_PLAY, 2, 0, 4, 0);
    Car_Collision = '0;
    Row_Enable = 5'b11111;

    // Hit beats goal in the same frame.
    Frog_Y = 11'd40;
    Car_Collision = 5'b00001;
    frame(S_DEAD, 1, 0, 4, 0);
    Frog_Y = 11'd200;
    Car_Collision = '0;
    for (int i = 1; i < 30; i++) frame(S_DEAD, 1, 0, 4, 0);
    frame(S_PLAY, 1, 0, 4, 0);

    // One pixel below the goal line is not a goal.
    Frog_Y = 11'd41;
    frame(S_PLAY, 1, 0, 4, 0);

    // Eight completions: Level saturates at 7, Speed lags Level by one frame.
    lvl = 0;
    sc = 0;
    for (int k = 0; k < 8; k++) begin
      int nl;
      Frog_Y = 11'd40;
      frame(S_LVUP, 1, lvl, spd(lvl), sc);
      Frog_Y = 11'd200;
      nl = (lvl < 7) ? lvl + 1 : 7;
      sc++;
      frame(S_PLAY, 1, nl, spd(lvl), sc);
      lvl = nl;
      frame(S_PLAY, 1, lvl, spd(lvl), sc);
    end

    // Last life lost: DEAD then GAME_OVER, which ignores hits and goals.
    Car_Collision = 5'b10000;
    frame(S_DEAD, 0, 7, 6'd25, 8);
    Car_Collision = '0;
    for (int i = 1; i < 30; i++) frame(S_DEAD, 0, 7, 6'd25, 8);
    frame(S_OVER, 0, 7, 6'd25, 8);
    Car_Collision = 5'b10000;
    Frog_Y = 11'd10;
    frame(S_OVER, 0, 7, 6'd25, 8);
    Car_Collision = '0;
    Frog_Y = 11'd200;

    // Restart from GAME_OVER; Speed follows the cleared Level one frame later.
    Start = 1'b1;
    frame(S_PLAY, 3, 0, 6'd25, 0);
    Start = 1'b0;
    frame(S_PLAY, 3, 0, 4, 0);

    // Held hit costs one life; async reset mid-DEAD returns to IDLE at once.
    Car_Collision = 5'b01000;
    for (int i = 0; i < 5; i++) frame(S_DEAD, 2, 0, 4, 0);
    Car_Collision = '0;
    reset_check();
    @(negedge frame_clk);
    frame(S_IDLE, 3, 0, 4, 0);
    frame(S_IDLE, 3, 0, 4, 0);

    @(negedge frame_clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
